// File: rtl/exmem_elastic_reg.sv
// exmem_elastic_reg: EX/MEM pipeline register with a one-entry skid buffer.
// The main register drives the MEM-side outputs. The skid register catches the
// one entry that EX may send while MEM stalls. readyE comes straight from a
// flop, so there is no combinational path from readyM to readyE.
// Optional feature: define EXMEM_PERF_CNT_EN to add the stall_cnt and
// flush_cnt performance counters as output ports.
module exmem_elastic_reg #(
  parameter int DATA_WIDTH             = 32,
  parameter int REGISTER_ADDRESS_WIDTH = 5,
  parameter int CTRL_WIDTH             = 5
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  input  logic                              validE,
  output logic                              readyE,
  input  logic [CTRL_WIDTH-1:0]             ctrlE,
  input  logic [4*DATA_WIDTH-1:0]           dataE,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdE,
  output logic                              validM,
  input  logic                              readyM,
  output logic [CTRL_WIDTH-1:0]             ctrlM,
  output logic [4*DATA_WIDTH-1:0]           dataM,
  output logic [REGISTER_ADDRESS_WIDTH-1:0] RdM
`ifdef EXMEM_PERF_CNT_EN
  ,
  output logic [31:0]                       stall_cnt,
  output logic [31:0]                       flush_cnt
`endif
);

  // Main register: its contents drive the M outputs.
  logic                              main_valid_r, main_valid_s;
  logic [CTRL_WIDTH-1:0]             main_ctrl_r, main_ctrl_s;
  logic [4*DATA_WIDTH-1:0]           main_data_r, main_data_s;
  logic [REGISTER_ADDRESS_WIDTH-1:0] main_rd_r, main_rd_s;

  // Skid register: holds the entry accepted while M was stalled.
  logic                              skid_valid_r, skid_valid_s;
  logic [CTRL_WIDTH-1:0]             skid_ctrl_r, skid_ctrl_s;
  logic [4*DATA_WIDTH-1:0]           skid_data_r, skid_data_s;
  logic [REGISTER_ADDRESS_WIDTH-1:0] skid_rd_r, skid_rd_s;

  // readyE is kept as a register that mirrors !skid_valid.
  logic ready_e_r;

  logic e_xfer_s;
  logic m_xfer_s;

  assign e_xfer_s = validE && ready_e_r;
  assign m_xfer_s = main_valid_r && readyM;

  // Next-state logic. Flush has top priority. Main refills from the skid before
  // it takes a new entry, which keeps the order of entries. A cleared main
  // entry has its control bits zeroed, so a bubble can never write memory or
  // the register file.
  always_comb begin
    main_valid_s = main_valid_r;
    main_ctrl_s  = main_ctrl_r;
    main_data_s  = main_data_r;
    main_rd_s    = main_rd_r;
    skid_valid_s = skid_valid_r;
    skid_ctrl_s  = skid_ctrl_r;
    skid_data_s  = skid_data_r;
    skid_rd_s    = skid_rd_r;
    if (flush) begin
      main_valid_s = 1'b0;
      main_ctrl_s  = '0;
      skid_valid_s = 1'b0;
    end else if (!main_valid_r || m_xfer_s) begin
      if (skid_valid_r) begin
        main_valid_s = 1'b1;
        main_ctrl_s  = skid_ctrl_r;
        main_data_s  = skid_data_r;
        main_rd_s    = skid_rd_r;
        skid_valid_s = 1'b0;
      end else if (e_xfer_s) begin
        main_valid_s = 1'b1;
        main_ctrl_s  = ctrlE;
        main_data_s  = dataE;
        main_rd_s    = RdE;
      end else begin
        main_valid_s = 1'b0;
        main_ctrl_s  = '0;
      end
    end else begin
      if (e_xfer_s) begin
        skid_valid_s = 1'b1;
        skid_ctrl_s  = ctrlE;
        skid_data_s  = dataE;
        skid_rd_s    = RdE;
      end else begin
        skid_valid_s = skid_valid_r;
      end
    end
  end

  // State register. An asynchronous reset clears every entry and reopens the E side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_r <= 1'b0;
      main_ctrl_r  <= '0;
      main_data_r  <= '0;
      main_rd_r    <= '0;
      skid_valid_r <= 1'b0;
      skid_ctrl_r  <= '0;
      skid_data_r  <= '0;
      skid_rd_r    <= '0;
      ready_e_r    <= 1'b1;
    end else begin
      main_valid_r <= main_valid_s;
      main_ctrl_r  <= main_ctrl_s;
      main_data_r  <= main_data_s;
      main_rd_r    <= main_rd_s;
      skid_valid_r <= skid_valid_s;
      skid_ctrl_r  <= skid_ctrl_s;
      skid_data_r  <= skid_data_s;
      skid_rd_r    <= skid_rd_s;
      ready_e_r    <= !skid_valid_s;
    end
  end

  assign readyE = ready_e_r;
  assign validM = main_valid_r;
  assign ctrlM  = main_ctrl_r;
  assign dataM  = main_data_r;
  assign RdM    = main_rd_r;

`ifdef EXMEM_PERF_CNT_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] flush_cnt_r;

  // Performance counters: count stalled M cycles and flush cycles. Both wrap freely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= 32'd0;
      flush_cnt_r <= 32'd0;
    end else begin
      if (main_valid_r && !readyM) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush) begin
        flush_cnt_r <= flush_cnt_r + 32'd1;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;
`endif

endmodule

// File: tb/tb_exmem_elastic_reg.sv
// Testbench for exmem_elastic_reg. The reference model keeps the held entries
// in a plain queue: at most two entries, the front one is the M output, and
// readyE is true when fewer than two entries are held.
module tb_exmem_elastic_reg;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 5;

  typedef struct {
    logic [CW-1:0]   ctrl;
    logic [4*DW-1:0] data;
    logic [AW-1:0]   rd;
  } ent_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic            validE;
  logic            readyE;
  logic [CW-1:0]   ctrlE;
  logic [4*DW-1:0] dataE;
  logic [AW-1:0]   RdE;
  logic            validM;
  logic            readyM;
  logic [CW-1:0]   ctrlM;
  logic [4*DW-1:0] dataM;
  logic [AW-1:0]   RdM;
`ifdef EXMEM_PERF_CNT_EN
  logic [31:0]     stall_cnt;
  logic [31:0]     flush_cnt;
  int unsigned     stall_m;
  int unsigned     flush_m;
`endif

  ent_t q[$];
  int   tests = 0;
  int   errors = 0;

  exmem_elastic_reg #(.DATA_WIDTH(DW), .REGISTER_ADDRESS_WIDTH(AW), .CTRL_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .validE(validE), .readyE(readyE),
    .ctrlE(ctrlE), .dataE(dataE), .RdE(RdE), .validM(validM), .readyM(readyM),
    .ctrlM(ctrlM), .dataM(dataM), .RdM(RdM)
`ifdef EXMEM_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [4*DW-1:0] act, input logic [4*DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare every DUT output against the queue model.
  task automatic compare_model();
    chk("validM", {127'd0, validM}, {127'd0, q.size() > 0});
    chk("readyE", {127'd0, readyE}, {127'd0, q.size() < 2});
    if (q.size() > 0) begin
      chk("ctrlM", {123'd0, ctrlM}, {123'd0, q[0].ctrl});
      chk("dataM", dataM, q[0].data);
      chk("RdM", {123'd0, RdM}, {123'd0, q[0].rd});
    end else begin
      chk("ctrlM_bubble", {123'd0, ctrlM}, 128'd0);
    end
`ifdef EXMEM_PERF_CNT_EN
    chk("stall_cnt", {96'd0, stall_cnt}, {96'd0, stall_m});
    chk("flush_cnt", {96'd0, flush_cnt}, {96'd0, flush_m});
`endif
  endtask

  // Apply one clock edge to the model and the DUT, then check on the falling edge.
  task automatic step();
    ent_t e;
    bit   acc;
    @(posedge clk);
    if (rst_n) begin
`ifdef EXMEM_PERF_CNT_EN
      if (q.size() > 0 && !readyM) stall_m++;
      if (flush) flush_m++;
`endif
      acc = validE && (q.size() < 2);
      if (flush) begin
        q.delete();
      end else begin
        if (q.size() > 0 && readyM) void'(q.pop_front());
        if (acc) begin
          e.ctrl = ctrlE; e.data = dataE; e.rd = RdE;
          q.push_back(e);
        end
      end
    end
    @(negedge clk);
    compare_model();
  endtask

  task automatic drive(input bit v, input bit rm, input bit fl, input logic [DW-1:0] pc);
    validE = v;
    readyM = rm;
    flush  = fl;
    ctrlE  = CW'($urandom);
    RdE    = AW'($urandom);
    dataE  = {32'($urandom), 32'($urandom), 32'($urandom), pc};
  endtask

  task automatic model_reset();
    q.delete();
`ifdef EXMEM_PERF_CNT_EN
    stall_m = 0;
    flush_m = 0;
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    model_reset();
    #12;
    // The reset state is pinned with literal values.
    chk("rst_validM", {127'd0, validM}, 128'd0);
    chk("rst_readyE", {127'd0, readyE}, 128'd1);
    chk("rst_ctrlM", {123'd0, ctrlM}, 128'd0);
    chk("rst_dataM", dataM, 128'd0);
    chk("rst_RdM", {123'd0, RdM}, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Stream test: eight entries with PCPlus4 = 4..32 appear one cycle after acceptance.
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 1'b1, 1'b0, 32'(4 * k));
      step();
      chk("stream_validM", {127'd0, validM}, 128'd1);
      chk("stream_pc", {96'd0, dataM[DW-1:0]}, {96'd0, 32'(4 * k)});
      chk("stream_readyE", {127'd0, readyE}, 128'd1);
    end
    drive(1'b0, 1'b1, 1'b0, 32'd0);
    step();

    // Backpressure test: A goes to main and B goes to the skid register, so readyE drops.
    drive(1'b1, 1'b0, 1'b0, 32'h100); step();
    drive(1'b1, 1'b0, 1'b0, 32'h104); step();
    chk("bp_readyE0", {127'd0, readyE}, 128'd0);
    chk("bp_holdA", {96'd0, dataM[DW-1:0]}, {96'd0, 32'h100});
    drive(1'b1, 1'b0, 1'b0, 32'h108); step();
    chk("bp_stillA", {96'd0, dataM[DW-1:0]}, {96'd0, 32'h100});
    drive(1'b0, 1'b1, 1'b0, 32'd0); step();
    chk("bp_drainB", {96'd0, dataM[DW-1:0]}, {96'd0, 32'h104});
    chk("bp_readyE1", {127'd0, readyE}, 128'd1);
    step();
    chk("bp_empty", {127'd0, validM}, 128'd0);

    // Flush test: both registers are full and validE=1 when flush is raised.
    drive(1'b1, 1'b0, 1'b0, 32'h200); step();
    drive(1'b1, 1'b0, 1'b0, 32'h204); step();
    drive(1'b1, 1'b1, 1'b1, 32'h208); step();
    chk("fl_validM", {127'd0, validM}, 128'd0);
    chk("fl_ctrlM", {123'd0, ctrlM}, 128'd0);
    chk("fl_readyE", {127'd0, readyE}, 128'd1);
    drive(1'b0, 1'b1, 1'b0, 32'd0); step();
    chk("fl_gone", {127'd0, validM}, 128'd0);

    // Async reset test: reset is asserted between edges in the middle of a stall.
    drive(1'b1, 1'b0, 1'b0, 32'h300); step();
    drive(1'b1, 1'b0, 1'b0, 32'h304); step();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("ar_validM", {127'd0, validM}, 128'd0);
    chk("ar_ctrlM", {123'd0, ctrlM}, 128'd0);
    chk("ar_readyE", {127'd0, readyE}, 128'd1);
    chk("ar_dataM", dataM, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'h400); step();
    chk("ar_first", {96'd0, dataM[DW-1:0]}, {96'd0, 32'h400});
    chk("ar_firstv", {127'd0, validM}, 128'd1);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(99, 0) < 70, $urandom_range(99, 0) < 55,
            $urandom_range(99, 0) < 3, 32'($urandom));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
